amm_ddr_responder: RTL and testbench

//  Avalon-MM responder (slave) end of the DDR setup master's 256-bit burst interface. It stands in for the EMIF user port in

---
 rtl/amm_ddr_pkg.sv | 40 ++++
 rtl/amm_rsp_ram.sv | 53 +++++
 rtl/amm_ddr_responder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_amm_ddr_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amm_ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amm_ddr_pkg
// Description : Shared types, widths and burst-count helpers for the
//               Avalon-MM DDR responder (amm_ddr_responder, amm_rsp_ram).
//               Contents: responder state enum, Avalon-MM field widths,
//               maximum burst length, burst-count validation functions.
// Revision    : 1.0 - initial release
// ============================================================================
package amm_ddr_pkg;

    localparam int AMM_AW    = 25;   // word address width
    localparam int AMM_DW    = 256;  // data width
    localparam int AMM_BEW   = 32;   // byte-enable width
    localparam int AMM_BCW   = 7;    // burstcount width
    localparam int MAX_BURST = 64;   // longest legal burst

    localparam logic [AMM_BCW-1:0] BC_ONE = 7'd1;
    localparam logic [AMM_BCW-1:0] BC_MAX = 7'd64;

    typedef enum logic [2:0] {
        CAL  = 3'd0,
        IDLE = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        FAIL = 3'd4
    } state_t;

    // A burstcount of 0 or above MAX_BURST is a protocol violation.
    function automatic logic burst_bad(input logic [AMM_BCW-1:0] bc);
        return (bc == '0) || (bc > BC_MAX);
    endfunction

    // Illegal burstcounts are served as single-beat transfers.
    function automatic logic [AMM_BCW-1:0] burst_len(input logic [AMM_BCW-1:0] bc);
        return burst_bad(bc) ? BC_ONE : bc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/amm_rsp_ram.sv
`default_nettype none
// ============================================================================
// Module      : amm_rsp_ram
// Description : 1R1W byte-enabled RAM, 2**ADDR_W words of DATA_W bits.
//               Writes are committed at the clock edge; read data is
//               registered (one cycle from raddr/re to rdata). Array
//               contents are not affected by reset; only the read register is.
// Ports       : clk, rst_n           - clock, async active-low reset
//               we, waddr, wdata, be - write port, per-byte enables
//               re, raddr            - read request and address
//               rdata                - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module amm_rsp_ram
    import amm_ddr_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = AMM_DW,
    parameter int BE_W   = AMM_BEW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/amm_ddr_responder.sv
`default_nettype none
// ============================================================================
// Module      : amm_ddr_responder
// Description : Avalon-MM responder standing in for a DDR EMIF user port.
//               Emulates calibration for CAL_CYCLES cycles, then serves
//               256-bit burst writes/reads from on-chip byte-enabled RAM with
//               a fixed read latency of RD_LAT cycles. Protocol violations
//               set a sticky protocol_err.
// Config      : AMM_BP_INJECT_EN - when defined, a 16-bit LFSR injects
//               pseudo-random amm_ready stalls in IDLE/WR.
// Ports       : clk, rst_n                   - clock, async active-low reset
//               amm_addr/writedata/byteenable/burstcount/write/read - request
//               amm_ready                    - transfer when req && amm_ready
//               amm_readdata/readdatavalid   - read return
//               local_cal_success/fail, ram_ready - calibration status
//               protocol_err                 - sticky protocol violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module amm_ddr_responder
    import amm_ddr_pkg::*;
#(
    parameter int MEM_AW     = 10,
    parameter int RD_LAT     = 4,
    parameter int CAL_CYCLES = 1000,
    parameter int CAL_FAIL   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AMM_AW-1:0]  amm_addr,
    input  logic [AMM_DW-1:0]  amm_writedata,
    input  logic [AMM_BEW-1:0] amm_byteenable,
    input  logic [AMM_BCW-1:0] amm_burstcount,
    input  logic               amm_write,
    input  logic               amm_read,
    output logic               amm_ready,
    output logic [AMM_DW-1:0]  amm_readdata,
    output logic               amm_readdatavalid,
    output logic               local_cal_success,
    output logic               local_cal_fail,
    output logic               ram_ready,
    output logic               protocol_err
);

    localparam logic [31:0]       CAL_LAST = CAL_CYCLES - 1;
    localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

    state_t               state;
    state_t               state_nxt;
    logic [31:0]          cal_cnt;
    logic                 cal_pass;
    logic                 cal_fail_flag;
    logic                 err_flag;
    logic [MEM_AW-1:0]    wr_ptr;
    logic [AMM_BCW-1:0]   wr_left;
    logic [MEM_AW-1:0]    rd_ptr;
    logic [AMM_BCW-1:0]   rd_left;
    logic                 stall;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 err_evt;
    logic [AMM_BCW-1:0]   bc_len;
    logic [MEM_AW-1:0]    req_addr;
    logic                 ram_re;
    logic [MEM_AW-1:0]    ram_raddr;
    logic [MEM_AW-1:0]    ram_waddr;
    logic [AMM_DW-1:0]    ram_rdata;
    logic                 iss_last;
    logic                 iss_v;      // valid aligned with ram_rdata
    logic                 iss_l;      // last-beat marker aligned with ram_rdata
    logic                 rsp_v;
    logic                 rsp_l;
    logic [AMM_DW-1:0]    rsp_d;

    // Upper address bits alias onto the RAM and are intentionally unused.
    logic unused_addr_hi;
    assign unused_addr_hi = ^amm_addr[AMM_AW-1:MEM_AW];

    // ------------------------------------------------------------------------
    // Optional backpressure injection
    // ------------------------------------------------------------------------
`ifdef AMM_BP_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (state != CAL) begin
            // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = ((state == IDLE) || (state == WR)) && (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign amm_ready = ((state == IDLE) || (state == WR)) && !stall;
    assign req_addr  = amm_addr[MEM_AW-1:0];
    assign bc_len    = burst_len(amm_burstcount);
    assign wr_acc    = amm_write && amm_ready;
    // Write wins when both are requested in IDLE.
    assign rd_acc    = (state == IDLE) && amm_read && !amm_write && amm_ready;

    assign err_evt = ((state == IDLE) && amm_ready && amm_read && amm_write)
                   || ((state == WR) && amm_read)
                   || ((state == IDLE) && (wr_acc || rd_acc) && burst_bad(amm_burstcount));

    // Beat 0 of a read is issued in the acceptance cycle itself so that the
    // RAM's one-cycle read plus RD_LAT-1 pipe stages lands on RD_LAT.
    assign ram_re    = rd_acc || ((state == RD) && (rd_left != '0));
    assign ram_raddr = (state == IDLE) ? req_addr : rd_ptr;
    assign iss_last  = rd_acc ? (bc_len == BC_ONE) : (rd_left == BC_ONE);
    assign ram_waddr = (state == IDLE) ? req_addr : wr_ptr;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CAL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CAL: begin
                if (cal_cnt == CAL_LAST) begin
                    state_nxt = (CAL_FAIL != 0) ? FAIL : IDLE;
                end
            end
            IDLE: begin
                if (wr_acc) begin
                    if (bc_len != BC_ONE) begin
                        state_nxt = WR;
                    end
                end else if (rd_acc) begin
                    state_nxt = RD;
                end
            end
            WR: begin
                if (wr_acc && (wr_left == BC_ONE)) begin
                    state_nxt = IDLE;
                end
            end
            RD: begin
                // Leave as the last beat is presented; IDLE accepts next cycle.
                if (rsp_v && rsp_l) begin
                    state_nxt = IDLE;
                end
            end
            FAIL:    state_nxt = FAIL;
            default: state_nxt = CAL;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_cnt       <= '0;
            cal_pass      <= 1'b0;
            cal_fail_flag <= 1'b0;
            err_flag      <= 1'b0;
            wr_ptr        <= '0;
            wr_left       <= '0;
            rd_ptr        <= '0;
            rd_left       <= '0;
            iss_v         <= 1'b0;
            iss_l         <= 1'b0;
        end else begin
            if (state == CAL) begin
                cal_cnt <= cal_cnt + 32'd1;
            end
            if ((state == CAL) && (state_nxt == IDLE)) begin
                cal_pass <= 1'b1;
            end
            if ((state == CAL) && (state_nxt == FAIL)) begin
                cal_fail_flag <= 1'b1;
            end
            if (err_evt) begin
                err_flag <= 1'b1;
            end

            if (wr_acc) begin
                if (state == IDLE) begin
                    wr_ptr  <= req_addr + ADDR_ONE;
                    wr_left <= bc_len - BC_ONE;
                end else begin
                    wr_ptr  <= wr_ptr + ADDR_ONE;
                    wr_left <= wr_left - BC_ONE;
                end
            end

            if (rd_acc) begin
                rd_ptr  <= req_addr + ADDR_ONE;
                rd_left <= bc_len - BC_ONE;
            end else if ((state == RD) && (rd_left != '0)) begin
                rd_ptr  <= rd_ptr + ADDR_ONE;
                rd_left <= rd_left - BC_ONE;
            end

            iss_v <= ram_re;
            iss_l <= ram_re && iss_last;
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    amm_rsp_ram #(
        .ADDR_W (MEM_AW),
        .DATA_W (AMM_DW),
        .BE_W   (AMM_BEW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (ram_waddr),
        .wdata (amm_writedata),
        .be    (amm_byteenable),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------------
    // Read-latency pipe (RD_LAT-1 stages after the RAM register)
    // ------------------------------------------------------------------------
    generate
        if (RD_LAT > 1) begin : g_pipe
            logic [RD_LAT-2:0] v_sr;
            logic [RD_LAT-2:0] l_sr;
            logic [AMM_DW-1:0] d_sr [RD_LAT-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_sr <= '0;
                    l_sr <= '0;
                    for (int k = 0; k < RD_LAT - 1; k++) begin
                        d_sr[k] <= '0;
                    end
                end else begin
                    v_sr[0] <= iss_v;
                    l_sr[0] <= iss_l;
                    d_sr[0] <= ram_rdata;
                    for (int k = 1; k < RD_LAT - 1; k++) begin
                        v_sr[k] <= v_sr[k-1];
                        l_sr[k] <= l_sr[k-1];
                        d_sr[k] <= d_sr[k-1];
                    end
                end
            end

            assign rsp_v = v_sr[RD_LAT-2];
            assign rsp_l = l_sr[RD_LAT-2];
            assign rsp_d = d_sr[RD_LAT-2];
        end else begin : g_nopipe
            assign rsp_v = iss_v;
            assign rsp_l = iss_l;
            assign rsp_d = ram_rdata;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign amm_readdatavalid = rsp_v;
    assign amm_readdata      = rsp_d;
    assign local_cal_success = cal_pass;
    assign local_cal_fail    = cal_fail_flag;
    assign ram_ready         = cal_pass;
    assign protocol_err      = err_flag;

endmodule
`default_nettype wire

// File: tb/tb_amm_ddr_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_amm_ddr_responder
// Description : Self-checking bench for amm_ddr_responder. A word-array memory
//               model and a queue of expected read beats (due cycle + data)
//               supply every expected value; random bursts are mixed with
//               directed calibration, byte-enable, wrap, collision and
//               mid-burst reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amm_ddr_responder;
    import amm_ddr_pkg::*;

    localparam int CAL   = 20;
    localparam int RDL   = 4;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [AMM_AW-1:0]  amm_addr;
    logic [AMM_DW-1:0]  amm_writedata;
    logic [AMM_BEW-1:0] amm_byteenable;
    logic [AMM_BCW-1:0] amm_burstcount;
    logic               amm_write;
    logic               amm_read;
    logic               amm_ready;
    logic [AMM_DW-1:0]  amm_readdata;
    logic               amm_readdatavalid;
    logic               local_cal_success;
    logic               local_cal_fail;
    logic               ram_ready;
    logic               protocol_err;

    amm_ddr_responder #(
        .MEM_AW     (AW),
        .RD_LAT     (RDL),
        .CAL_CYCLES (CAL),
        .CAL_FAIL   (0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .amm_addr          (amm_addr),
        .amm_writedata     (amm_writedata),
        .amm_byteenable    (amm_byteenable),
        .amm_burstcount    (amm_burstcount),
        .amm_write         (amm_write),
        .amm_read          (amm_read),
        .amm_ready         (amm_ready),
        .amm_readdata      (amm_readdata),
        .amm_readdatavalid (amm_readdatavalid),
        .local_cal_success (local_cal_success),
        .local_cal_fail    (local_cal_fail),
        .ram_ready         (ram_ready),
        .protocol_err      (protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        logic [255:0] d;
    } beat_t;

    beat_t        sb[$];
    int           beats_seen = 0;
    logic [255:0] mem_m [DEPTH];

    function automatic int blen(input int bc);
        int b = bc & 127;
        return (b == 0 || b > 64) ? 1 : b;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Read-return monitor: every valid beat must match the head of the queue
    // in both cycle and data; a due beat that never shows is reported.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (amm_readdatavalid) begin
                if (sb.size() == 0) begin
                    check("rdv_unexpected", 256'(amm_readdatavalid), 256'd0);
                end else begin
                    b = sb.pop_front();
                    check("rdv_cycle", 256'(cyc), 256'(b.due));
                    check("rdv_data", amm_readdata, b.d);
                    beats_seen++;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("rdv_missing", 256'(amm_readdatavalid), 256'd1);
                void'(sb.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int t = 0;
        while (!amm_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("ready_wait", 256'(amm_ready), 256'd1);
    endtask

    task automatic wr_burst(input int addr, input int bc, input logic [31:0] be,
                            input bit also_read, input bit fix, input logic [255:0] fdata);
        int n = blen(bc);
        for (int i = 0; i < n; i++) begin
            logic [255:0] wd;
            int a;
            @(negedge clk);
            wd = fix ? fdata : rnd256();
            amm_write      = 1'b1;
            amm_writedata  = wd;
            amm_byteenable = be;
            if (i == 0) begin
                amm_addr       = AMM_AW'(addr);
                amm_burstcount = AMM_BCW'(bc);
                amm_read       = also_read;
            end else begin
                amm_addr       = AMM_AW'($urandom);
                amm_burstcount = AMM_BCW'($urandom);
                amm_read       = 1'b0;
            end
            #1;
            wait_ready();
            @(posedge clk);
            a = (addr + i) % DEPTH;
            for (int b = 0; b < 32; b++)
                if (be[b]) mem_m[a][b*8 +: 8] = wd[b*8 +: 8];
        end
        @(negedge clk);
        amm_write = 1'b0;
        amm_read  = 1'b0;
    endtask

    task automatic rd_issue(input int addr, input int bc);
        int n = blen(bc);
        beat_t b;
        @(negedge clk);
        amm_read       = 1'b1;
        amm_addr       = AMM_AW'(addr);
        amm_burstcount = AMM_BCW'(bc);
        #1;
        wait_ready();
        // Acceptance happens at the next posedge; beat i is visible after
        // edge (accept + RDL - 1 + i), i.e. at negedge with cyc = now + RDL + i.
        for (int i = 0; i < n; i++) begin
            b.due = cyc + RDL + i;
            b.d   = mem_m[(addr + i) % DEPTH];
            sb.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
        amm_read = 1'b0;
    endtask

    task automatic wait_rd_done();
        int t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while ((sb.size() != 0 || !amm_ready) && t < 300);
        check("rd_done", 256'(sb.size() == 0 && amm_ready), 256'd1);
    endtask

    task automatic rd_burst(input int addr, input int bc);
        rd_issue(addr, bc);
        wait_rd_done();
    endtask

    task automatic hold_reset();
        rst_n     = 1'b0;
        amm_write = 1'b0;
        amm_read  = 1'b0;
        sb.delete();
        #1;
        check("rst_rdv", 256'(amm_readdatavalid), 256'd0);
        check("rst_rdata", amm_readdata, 256'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_rdv_hold", 256'(amm_readdatavalid), 256'd0);
            check("rst_ready", 256'(amm_ready), 256'd0);
            check("rst_cal_ok", 256'(local_cal_success), 256'd0);
            check("rst_err", 256'(protocol_err), 256'd0);
        end
    endtask

    task automatic recal();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= CAL + 1; k++) begin
            @(posedge clk);
            #1;
            check("cal_success", 256'(local_cal_success), 256'(k >= CAL));
            check("cal_ready", 256'(amm_ready), 256'(k >= CAL));
            check("cal_ram_ready", 256'(ram_ready), 256'(k >= CAL));
            check("cal_fail", 256'(local_cal_fail), 256'd0);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        int target;
        int t;
        rst_n          = 1'b0;
        amm_addr       = '0;
        amm_writedata  = '0;
        amm_byteenable = '0;
        amm_burstcount = '0;
        amm_write      = 1'b0;
        amm_read       = 1'b0;

        // calibration after reset release
        hold_reset();
        recal();
        check("err_after_cal", 256'(protocol_err), 256'd0);

        // prefill the random-traffic window
        wr_burst(0, 32, '1, 1'b0, 1'b0, '0);
        wr_burst(32, 32, '1, 1'b0, 1'b0, '0);

        // 4-beat write/read
        wr_burst(16, 4, '1, 1'b0, 1'b0, '0);
        rd_burst(16, 4);

        // byte-enable merge: all-FF then byte 0 cleared
        wr_burst(5, 1, '1, 1'b0, 1'b1, {256{1'b1}});
        wr_burst(5, 1, 32'h0000_0001, 1'b0, 1'b1, '0);
        check("be_model", mem_m[5], {{248{1'b1}}, 8'h00});
        rd_burst(5, 1);

        // wrap at top of memory
        wr_burst(DEPTH - 1, 3, '1, 1'b0, 1'b0, '0);
        rd_burst(DEPTH - 1, 3);
        check("err_clean", 256'(protocol_err), 256'd0);

        // read and write in the same IDLE cycle: write wins, no read data
        wr_burst(40, 1, '1, 1'b1, 1'b0, '0);
        repeat (RDL + 3) @(negedge clk);
        #1;
        check("err_collision", 256'(protocol_err), 256'd1);
        rd_burst(40, 1);

        // randomized traffic in the prefilled window
        for (int i = 0; i < 40; i++) begin
            int r  = $urandom_range(0, 9);
            int bc = (r < 8) ? r + 1 : ((r == 8) ? 0 : 100);
            int a  = $urandom_range(0, 55);
            if ($urandom_range(0, 1) == 0) wr_burst(a, bc, $urandom, 1'b0, 1'b0, '0);
            else                           rd_burst(a, bc);
        end
        check("err_sticky", 256'(protocol_err), 256'd1);

        // reset during an 8-beat read, after beat 1
        rd_issue(0, 8);
        target = beats_seen + 2;
        t = 0;
        while (beats_seen < target && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("beats_before_rst", 256'(beats_seen >= target), 256'd1);
        hold_reset();
        recal();
        check("err_cleared", 256'(protocol_err), 256'd0);

        // RAM contents survive reset
        rd_burst(0, 8);

        // burstcount 0 is an error, served as one beat
        wr_burst(8, 0, '1, 1'b0, 1'b0, '0);
        #1;
        check("err_bc0", 256'(protocol_err), 256'd1);
        rd_burst(8, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
